// File: rtl/memory_bank_pkg.sv
// Shared types and constants for the multi-slot signed-BCD memory bank.
// Slots are sized for the widest legal configuration; unused upper digits stay zero.
package memory_bank_pkg;

  localparam int MAX_DIGITS = 7;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_STORE     = 3'b001;
  localparam logic [2:0] OP_RECALL    = 3'b010;
  localparam logic [2:0] OP_CLEAR     = 3'b011;
  localparam logic [2:0] OP_ADD       = 3'b100;
  localparam logic [2:0] OP_SUB       = 3'b101;
  localparam logic [2:0] OP_CLEAR_ALL = 3'b110;
  localparam logic [2:0] OP_RSVD      = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ARITH,
    WRITE
  } stateT;

  typedef struct packed {
    logic                       sign;
    logic [MAX_DIGITS-1:0][3:0] mag;
  } slotT;

  function automatic logic hasBadDigit(input logic [MAX_DIGITS-1:0][3:0] mag);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (mag[i] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/memory_bank_if.sv
// Request/response bundle between the calculator FSM and the memory bank.
interface memory_bank_if #(
  parameter int SLOTS = 4
);
  localparam int SW = $clog2(SLOTS);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [SW-1:0]    slot_sel;
  logic [31:0]      bcd_in;
  logic [31:0]      bcd_out;
  logic [SLOTS-1:0] slot_used;
  logic             done;
  logic             err;

  modport master (
    output op_valid, op_code, slot_sel, bcd_in,
    input  op_ready, bcd_out, slot_used, done, err
  );

  modport slave (
    input  op_valid, op_code, slot_sel, bcd_in,
    output op_ready, bcd_out, slot_used, done, err
  );

endinterface

// File: rtl/memory_bank_bcd_digit_addsub.sv
// Single BCD digit adder/subtractor with decimal correction; carry doubles as borrow.
module bcd_digit_addsub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic       carryIn,
  output logic [3:0] sum,
  output logic       carryOut
);

  logic [4:0] raw;

  always_comb begin
    raw      = '0;
    sum      = '0;
    carryOut = 1'b0;
    if (!sub) begin
      raw = {1'b0, a} + {1'b0, b} + {4'b0000, carryIn};
      if (raw > 5'd9) begin
        sum      = raw[3:0] + 4'd6;
        carryOut = 1'b1;
      end else begin
        sum = raw[3:0];
      end
    end else begin
      // A negative difference wraps in 5 bits; adding ten restores the decimal digit.
      raw = {1'b0, a} - {1'b0, b} - {4'b0000, carryIn};
      if (raw[4]) begin
        sum      = raw[3:0] + 4'd10;
        carryOut = 1'b1;
      end else begin
        sum = raw[3:0];
      end
    end
  end

endmodule

// File: rtl/memory_bank.sv
// Multi-slot signed-BCD memory with store/recall/clear and digit-serial M+/M-.
// Arithmetic always subtracts the smaller magnitude from the larger, so no final borrow exists.
module memory_bank
  import memory_bank_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int SLOTS  = 4
) (
  input logic          clk,
  input logic          rst_n,
  memory_bank_if.slave bus
);

  localparam int SW    = $clog2(SLOTS);
  localparam int MAG_W = 4 * MAX_DIGITS;
  localparam logic [MAG_W-1:0] MAG_MASK   = (28'd1 << (4 * DIGITS)) - 28'd1;
  localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);

  stateT state;
  stateT nextState;
  logic  opReady;

  slotT                       slots [SLOTS];
  logic [SLOTS-1:0]           slotUsed;
  logic [SW-1:0]              targetSlot;
  logic [MAX_DIGITS-1:0][3:0] opA;
  logic [MAX_DIGITS-1:0][3:0] opB;
  logic [MAX_DIGITS-1:0][3:0] resMag;
  logic                       resSign;
  logic                       subMode;
  logic                       carry;
  logic                       badDigit;
  logic [2:0]                 digitIdx;
  logic [31:0]                bcdOut;
  logic                       doneReg;
  logic                       errReg;

  logic                       transfer;
  logic [MAX_DIGITS-1:0][3:0] inMag;
  logic                       inSign;
  slotT                       curSlot;
  logic [3:0]                 digitSum;
  logic                       digitCarry;

  assign inMag    = bus.bcd_in[MAG_W-1:0] & MAG_MASK;
  assign inSign   = bus.bcd_in[31] ^ (bus.op_code == OP_SUB);
  assign curSlot  = slots[bus.slot_sel];
  assign transfer = bus.op_valid && opReady;

  assign bus.op_ready  = opReady;
  assign bus.bcd_out   = bcdOut;
  assign bus.slot_used = slotUsed;
  assign bus.done      = doneReg;
  assign bus.err       = errReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    opReady   = 1'b0;
    case (state)
      IDLE: begin
        opReady = 1'b1;
        if (bus.op_valid && (bus.op_code == OP_ADD || bus.op_code == OP_SUB)) nextState = ARITH;
      end
      ARITH: begin
        if (digitIdx == LAST_DIGIT) nextState = WRITE;
      end
      WRITE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  bcd_digit_addsub digitUnit (
    .a        (opA[digitIdx]),
    .b        (opB[digitIdx]),
    .sub      (subMode),
    .carryIn  (carry),
    .sum      (digitSum),
    .carryOut (digitCarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
      slotUsed   <= '0;
      targetSlot <= '0;
      opA        <= '0;
      opB        <= '0;
      resMag     <= '0;
      resSign    <= 1'b0;
      subMode    <= 1'b0;
      carry      <= 1'b0;
      badDigit   <= 1'b0;
      digitIdx   <= '0;
      bcdOut     <= '0;
      doneReg    <= 1'b0;
      errReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      errReg  <= 1'b0;
      bcdOut  <= bus.bcd_in;

      if (transfer) begin
        case (bus.op_code)
          OP_STORE: begin
            slots[bus.slot_sel]    <= '{sign: bus.bcd_in[31] && (inMag != '0), mag: inMag};
            slotUsed[bus.slot_sel] <= 1'b1;
            doneReg                <= 1'b1;
          end
          OP_RECALL: begin
            bcdOut  <= {{4{curSlot.sign}}, curSlot.mag};
            doneReg <= 1'b1;
          end
          OP_CLEAR: begin
            slots[bus.slot_sel]    <= '0;
            slotUsed[bus.slot_sel] <= 1'b0;
            doneReg                <= 1'b1;
          end
          OP_CLEAR_ALL: begin
            for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
            slotUsed <= '0;
            doneReg  <= 1'b1;
          end
          OP_ADD, OP_SUB: begin
            targetSlot <= bus.slot_sel;
            digitIdx   <= '0;
            carry      <= 1'b0;
            resMag     <= '0;
            badDigit   <= hasBadDigit(curSlot.mag) || hasBadDigit(inMag);
            // Order operands so the serial unit only ever computes larger minus smaller.
            if (inSign == curSlot.sign) begin
              opA     <= curSlot.mag;
              opB     <= inMag;
              subMode <= 1'b0;
              resSign <= curSlot.sign;
            end else if (inMag > curSlot.mag) begin
              opA     <= inMag;
              opB     <= curSlot.mag;
              subMode <= 1'b1;
              resSign <= inSign;
            end else begin
              opA     <= curSlot.mag;
              opB     <= inMag;
              subMode <= 1'b1;
              resSign <= curSlot.sign;
            end
          end
          default: begin
          end
        endcase
      end

      if (state == ARITH) begin
        resMag[digitIdx] <= digitSum;
        carry            <= digitCarry;
        digitIdx         <= digitIdx + 3'd1;
      end

      if (state == WRITE) begin
        doneReg <= 1'b1;
        errReg  <= badDigit || carry;
        if (!(badDigit || carry)) begin
          slots[targetSlot]    <= '{sign: resSign && (resMag != '0), mag: resMag};
          slotUsed[targetSlot] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_bank.sv
// Self-checking bench for memory_bank: directed scenarios plus random traffic against
// a signed-integer reference model of the slots.
module tb_memory_bank;
  import memory_bank_pkg::*;

  localparam int DIGITS  = 3;
  localparam int SLOTS   = 4;
  localparam int MW      = 4 * DIGITS;
  localparam int MAX_MAG = 10 ** DIGITS - 1;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memory_bank_if #(.SLOTS(SLOTS)) bus ();

  memory_bank #(.DIGITS(DIGITS), .SLOTS(SLOTS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic             mSign [SLOTS];
  logic [MW-1:0]    mMag  [SLOTS];
  logic [SLOTS-1:0] mUsed;
  int passCount  = 0;
  int checkCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  function automatic bit magValid(input logic [MW-1:0] m);
    for (int i = 0; i < DIGITS; i++) if (m[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int magToInt(input logic [MW-1:0] m);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(m[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [MW-1:0] intToMag(input int v);
    logic [MW-1:0] m;
    int rest = v;
    for (int i = 0; i < DIGITS; i++) begin
      m[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return m;
  endfunction

  function automatic logic [31:0] recallValue(input logic [1:0] sel);
    logic [31:0] r = '0;
    r[31:28]  = {4{mSign[sel]}};
    r[MW-1:0] = mMag[sel];
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SLOTS; i++) begin
      mSign[i] = 1'b0;
      mMag[i]  = '0;
    end
    mUsed = '0;
  endtask

  task automatic modelStep(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] val,
                           output logic expErr);
    int slotVal, opVal, total;
    expErr = 1'b0;
    case (op)
      OP_STORE: begin
        mMag[sel]  = val[MW-1:0];
        mSign[sel] = val[31] && (val[MW-1:0] != '0);
        mUsed[sel] = 1'b1;
      end
      OP_CLEAR: begin
        mMag[sel]  = '0;
        mSign[sel] = 1'b0;
        mUsed[sel] = 1'b0;
      end
      OP_CLEAR_ALL: modelReset();
      OP_ADD, OP_SUB: begin
        if (!magValid(mMag[sel]) || !magValid(val[MW-1:0])) begin
          expErr = 1'b1;
        end else begin
          slotVal = mSign[sel] ? -magToInt(mMag[sel]) : magToInt(mMag[sel]);
          opVal   = magToInt(val[MW-1:0]);
          if ((op == OP_SUB) ^ val[31]) opVal = -opVal;
          total = slotVal + opVal;
          if (total > MAX_MAG || total < -MAX_MAG) begin
            expErr = 1'b1;
          end else begin
            mSign[sel] = (total < 0);
            mMag[sel]  = intToMag(total < 0 ? -total : total);
            mUsed[sel] = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus.op_ready && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.op_ready) checkOutput("readyTimeout", bus.op_ready, 1);
  endtask

  task automatic waitDone(output int edges, output int lowCycles);
    edges = 0;
    lowCycles = 0;
    while (!bus.done && edges < TIMEOUT) begin
      if (!bus.op_ready) lowCycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] sel, input logic [31:0] val);
    logic expErr;
    int edges, lowCycles;
    waitReady();
    bus.op_code  = op;
    bus.slot_sel = sel;
    bus.bcd_in   = val;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    bus.bcd_in   = $urandom();
    modelStep(op, sel, val, expErr);
    case (op)
      OP_ADD, OP_SUB: begin
        checkOutput("arithPassThru", bus.bcd_out, val);
        waitDone(edges, lowCycles);
        checkOutput("arithDone", bus.done, 1);
        checkOutput("arithLatency", edges, DIGITS + 1);
        checkOutput("arithBusy", lowCycles, DIGITS + 1);
        checkOutput("arithErr", bus.err, expErr);
        checkOutput("arithReadyAgain", bus.op_ready, 1);
        checkOutput("arithUsed", bus.slot_used, mUsed);
      end
      OP_NOP, OP_RSVD: begin
        checkOutput("nopDone", bus.done, 0);
        checkOutput("nopPassThru", bus.bcd_out, val);
        checkOutput("nopUsed", bus.slot_used, mUsed);
      end
      default: begin
        checkOutput("opDone", bus.done, 1);
        checkOutput("opErr", bus.err, 0);
        checkOutput("opUsed", bus.slot_used, mUsed);
        if (op == OP_RECALL) checkOutput("recallOut", bus.bcd_out, recallValue(sel));
        else                 checkOutput("opPassThru", bus.bcd_out, val);
      end
    endcase
  endtask

  function automatic logic [31:0] randVal(input logic [1:0] sel);
    logic [31:0] v = $urandom();
    int badPos;
    if ($urandom_range(0, 1) == 0) v[30:MW] = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) v[MW-1:0] = mMag[sel];
    if ($urandom_range(0, 11) == 0) begin
      badPos = $urandom_range(0, DIGITS - 1);
      v[4*badPos +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    logic        expErr;
    int          edges, lowCycles;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic [2:0]  opTable [16];

    opTable = '{OP_STORE, OP_STORE, OP_STORE, OP_RECALL, OP_RECALL, OP_RECALL, OP_ADD, OP_ADD,
                OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_CLEAR, OP_CLEAR_ALL, OP_NOP, OP_RSVD};

    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    bus.slot_sel = '0;
    bus.bcd_in   = '0;
    rst_n        = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBcdOut", bus.bcd_out, 0);
    checkOutput("rstUsed", bus.slot_used, 0);
    checkOutput("rstReady", bus.op_ready, 1);
    checkOutput("rstDone", bus.done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset and signed store/recall");
    applyStimulus(OP_RECALL, 2'd3, 32'h1234_5678);
    checkOutput("rstRecall3", bus.bcd_out, 32'h0000_0000);
    applyStimulus(OP_STORE, 2'd2, 32'h8000_0123);
    applyStimulus(OP_RECALL, 2'd2, 32'h0000_0000);
    checkOutput("signedRecall", bus.bcd_out, 32'hF000_0123);
    checkOutput("signedUsed", bus.slot_used, 4'b0100);

    $display("[TB] M+ and M- with mixed signs");
    applyStimulus(OP_STORE, 2'd1, 32'h0000_0456);
    applyStimulus(OP_ADD, 2'd1, 32'h8000_0500);
    applyStimulus(OP_RECALL, 2'd1, 32'h0);
    checkOutput("mixedAdd", bus.bcd_out, 32'hF000_0044);
    applyStimulus(OP_SUB, 2'd1, 32'h8000_0044);
    applyStimulus(OP_RECALL, 2'd1, 32'h0);
    checkOutput("subToZero", bus.bcd_out, 32'h0000_0000);

    $display("[TB] overflow and invalid digits");
    applyStimulus(OP_STORE, 2'd0, 32'h0000_0999);
    applyStimulus(OP_ADD, 2'd0, 32'h0000_0001);
    checkOutput("ovfErr", bus.err, 1);
    applyStimulus(OP_RECALL, 2'd0, 32'h0);
    checkOutput("ovfKeep", bus.bcd_out, 32'h0000_0999);
    applyStimulus(OP_ADD, 2'd0, 32'h0000_01A0);
    checkOutput("badDigitErr", bus.err, 1);

    $display("[TB] request ignored while busy");
    applyStimulus(OP_STORE, 2'd0, 32'h0000_0100);
    waitReady();
    bus.op_code  = OP_ADD;
    bus.slot_sel = 2'd0;
    bus.bcd_in   = 32'h0000_0023;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    modelStep(OP_ADD, 2'd0, 32'h0000_0023, expErr);
    bus.op_code = OP_STORE;
    bus.bcd_in  = 32'h0000_0777;
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
    waitDone(edges, lowCycles);
    checkOutput("busyDone", bus.done, 1);
    checkOutput("busyErr", bus.err, expErr);
    applyStimulus(OP_RECALL, 2'd0, 32'h0);
    checkOutput("busyRecall", bus.bcd_out, 32'h0000_0123);

    $display("[TB] CLEAR versus CLEAR_ALL");
    for (int i = 0; i < SLOTS; i++) applyStimulus(OP_STORE, 2'(i), 32'h0000_0011 * (i + 1));
    applyStimulus(OP_CLEAR, 2'd1, 32'h0);
    checkOutput("clearUsed", bus.slot_used, 4'b1101);
    applyStimulus(OP_CLEAR_ALL, 2'd0, 32'h0);
    checkOutput("clearAllUsed", bus.slot_used, 4'b0000);
    for (int i = 0; i < SLOTS; i++) begin
      applyStimulus(OP_RECALL, 2'(i), 32'hFFFF_FFFF);
      checkOutput("clearAllRecall", bus.bcd_out, 32'h0);
    end

    $display("[TB] reset during arithmetic");
    applyStimulus(OP_STORE, 2'd0, 32'h0000_0250);
    waitReady();
    bus.op_code  = OP_ADD;
    bus.slot_sel = 2'd0;
    bus.bcd_in   = 32'h0000_0001;
    bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstDone", bus.done, 0);
    checkOutput("midRstReady", bus.op_ready, 1);
    checkOutput("midRstUsed", bus.slot_used, 0);
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    edges = 0;
    repeat (2 * DIGITS) begin
      @(posedge clk); #1;
      if (bus.done) edges++;
    end
    checkOutput("midRstNoDone", edges, 0);
    applyStimulus(OP_RECALL, 2'd0, 32'h0);
    checkOutput("midRstSlot", bus.bcd_out, 32'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 250; n++) begin
      op  = opTable[$urandom_range(0, 15)];
      if (op == OP_CLEAR_ALL && $urandom_range(0, 3) != 0) op = OP_RECALL;
      sel = 2'($urandom_range(0, SLOTS - 1));
      applyStimulus(op, sel, randVal(sel));
    end
    for (int i = 0; i < SLOTS; i++) applyStimulus(OP_RECALL, 2'(i), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
